neuron_pe: RTL and testbench

- Parametrised fixed-point neuron processing element. Successor to the fixed 2-input ReLU neuron.
- Performs a forward pass: an N-input dot product plus bias, followed by a run-time selectable activation.
- Performs a backward pass: computes the local gradient, updates weights and bias in place, and emits input gradients for the previous layer.
- Instantiated per neuron inside a layer; a layer controller drives it with start/done handshakes.

---
 rtl/nn_pkg.sv | 34 +++
 rtl/fx_mul_sat.sv | 18 +
 rtl/neuron_pe.sv | 206 ++++++++++++++++++++
 tb/tb_neuron_pe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron PE: activation encodings, FSM states and
// the fixed-point rescale-and-saturate helper.
package nn_pkg;

  localparam logic [1:0] ACT_LIN   = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;

  localparam int LEAKY_SHIFT = 3;

  typedef enum logic [2:0] {
    IDLE,
    FP_MAC,
    FP_ACT,
    BP_GRAD,
    BP_UPD
  } state_t;

  // Floor-shift a wide signed value by frac, then clamp to a signed bits-wide range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] p,
                                                    input int frac,
                                                    input int bits);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = p >>> frac;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply: exposes the raw full-width
// product and the rescaled, saturated result.
module fx_mul_sat
  import nn_pkg::*;
#(
  parameter int BITS = 16,
  parameter int FRAC = 8
) (
  input  logic signed [BITS-1:0]   i_a,
  input  logic signed [BITS-1:0]   i_b,
  output logic signed [2*BITS-1:0] o_prod,
  output logic signed [BITS-1:0]   o_res
);

  assign o_prod = i_a * i_b;
  assign o_res  = BITS'(sat_shift(64'(o_prod), FRAC, BITS));

endmodule

// File: rtl/neuron_pe.sv
// Fixed-point neuron: N-input dot product + bias with selectable activation,
// and an in-place backward pass (weight/bias update, input gradients).
module neuron_pe
  import nn_pkg::*;
#(
  parameter int N     = 4,
  parameter int BITS  = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        act_mode,
  input  logic              w_load,
  input  logic [N*BITS-1:0] w_init,
  input  logic [BITS-1:0]   b_init,
  input  logic              fp_start,
  input  logic [N*BITS-1:0] x,
  input  logic              bp_start,
  input  logic [BITS-1:0]   dz_in,
  input  logic [BITS-1:0]   lr,
  output logic              busy,
  output logic [BITS-1:0]   y,
  output logic              y_valid,
  output logic [N*BITS-1:0] dx,
  output logic [N*BITS-1:0] w_out,
  output logic [BITS-1:0]   b_out,
  output logic              bp_done
);

  localparam int STEPS = N / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = 2*BITS + $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(STEPS - 1);

  typedef logic signed [BITS-1:0] data_t;

  state_t r_state;
  state_t w_next;
  logic [CW-1:0] r_cnt;
  data_t r_w [N];
  data_t r_x [N];
  data_t r_dx [N];
  data_t r_b, r_z, r_y, r_dzl, r_g, r_dz, r_lr;
  logic signed [AW-1:0] r_acc;
  logic r_y_valid, r_bp_done;

  logic [IW-1:0] w_idx [LANES];
  data_t w_ma_b [LANES];
  data_t w_ma_res [LANES];
  data_t w_mb_res [LANES];
  data_t w_wnew [LANES];
  logic signed [2*BITS-1:0] w_ma_prod [LANES];
  logic signed [2*BITS-1:0] w_mb_prod_unused [LANES];
  logic signed [2*BITS-1:0] w_g_prod_unused;
  logic signed [AW-1:0] w_acc_sum;
  data_t w_z, w_y_act, w_dzl, w_g, w_bnew;

  // Lane A is shared: w*x while accumulating, w*dzl while updating.
  for (genvar gk = 0; gk < LANES; gk++) begin : g_lane
    assign w_idx[gk]  = IW'(int'(r_cnt) * LANES + gk);
    assign w_ma_b[gk] = (r_state == FP_MAC) ? r_x[w_idx[gk]] : r_dzl;

    fx_mul_sat #(.BITS(BITS), .FRAC(FRAC)) u_mul_a (
      .i_a   (r_w[w_idx[gk]]),
      .i_b   (w_ma_b[gk]),
      .o_prod(w_ma_prod[gk]),
      .o_res (w_ma_res[gk])
    );

    fx_mul_sat #(.BITS(BITS), .FRAC(FRAC)) u_mul_b (
      .i_a   (r_g),
      .i_b   (r_x[w_idx[gk]]),
      .o_prod(w_mb_prod_unused[gk]),
      .o_res (w_mb_res[gk])
    );

    assign w_wnew[gk] = BITS'(sat_shift(64'(r_w[w_idx[gk]]) - 64'(w_mb_res[gk]), 0, BITS));
  end

  fx_mul_sat #(.BITS(BITS), .FRAC(FRAC)) u_mul_g (
    .i_a   (r_lr),
    .i_b   (w_dzl),
    .o_prod(w_g_prod_unused),
    .o_res (w_g)
  );

  always_comb begin
    w_acc_sum = r_acc;
    for (int k = 0; k < LANES; k++) w_acc_sum = w_acc_sum + AW'(w_ma_prod[k]);
  end

  assign w_z    = BITS'(sat_shift(64'(r_acc) + (64'(r_b) <<< FRAC), FRAC, BITS));
  assign w_bnew = BITS'(sat_shift(64'(r_b) - 64'(r_g), 0, BITS));

  always_comb begin
    w_y_act = '0;
    w_dzl   = '0;
    case (act_mode)
      ACT_LIN: begin
        w_y_act = w_z;
        w_dzl   = r_dz;
      end
      ACT_LEAKY: begin
        w_y_act = (w_z > 0) ? w_z : (w_z >>> LEAKY_SHIFT);
        w_dzl   = (r_z > 0) ? r_dz : (r_dz >>> LEAKY_SHIFT);
      end
      default: begin
        w_y_act = (w_z > 0) ? w_z : '0;
        w_dzl   = (r_z > 0) ? r_dz : '0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (fp_start)      w_next = FP_MAC;
        else if (bp_start) w_next = BP_GRAD;
      end
      FP_MAC:  if (r_cnt == C_LAST) w_next = FP_ACT;
      FP_ACT:  w_next = IDLE;
      BP_GRAD: w_next = BP_UPD;
      BP_UPD:  if (r_cnt == C_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_z       <= '0;
      r_y       <= '0;
      r_dzl     <= '0;
      r_g       <= '0;
      r_dz      <= '0;
      r_lr      <= '0;
      r_y_valid <= 1'b0;
      r_bp_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_w[i]  <= '0;
        r_x[i]  <= '0;
        r_dx[i] <= '0;
      end
    end else begin
      r_state   <= w_next;
      r_y_valid <= 1'b0;
      r_bp_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (fp_start) begin
            r_acc <= '0;
            for (int i = 0; i < N; i++) r_x[i] <= x[i*BITS +: BITS];
          end else if (bp_start) begin
            r_dz <= dz_in;
            r_lr <= lr;
          end else if (w_load) begin
            r_b <= b_init;
            for (int i = 0; i < N; i++) r_w[i] <= w_init[i*BITS +: BITS];
          end
        end
        FP_MAC: begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + 1'b1;
        end
        FP_ACT: begin
          r_z       <= w_z;
          r_y       <= w_y_act;
          r_y_valid <= 1'b1;
        end
        BP_GRAD: begin
          r_dzl <= w_dzl;
          r_g   <= w_g;
        end
        BP_UPD: begin
          for (int k = 0; k < LANES; k++) begin
            r_dx[w_idx[k]] <= w_ma_res[k];
            r_w[w_idx[k]]  <= w_wnew[k];
          end
          if (r_cnt == '0) r_b <= w_bnew;
          if (r_cnt == C_LAST) r_bp_done <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign b_out   = r_b;
  assign bp_done = r_bp_done;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign dx[gi*BITS +: BITS]    = r_dx[gi];
    assign w_out[gi*BITS +: BITS] = r_w[gi];
  end

endmodule

// File: tb/tb_neuron_pe.sv
// Scoreboard bench for neuron_pe (N=4, LANES=2, Q8.8) against an integer reference model.
module tb_neuron_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  act_mode;
  logic        w_load;
  logic [63:0] w_init;
  logic [15:0] b_init;
  logic        fp_start;
  logic [63:0] x;
  logic        bp_start;
  logic [15:0] dz_in;
  logic [15:0] lr;
  logic        busy;
  logic [15:0] y;
  logic        y_valid;
  logic [63:0] dx;
  logic [63:0] w_out;
  logic [15:0] b_out;
  logic        bp_done;

  neuron_pe #(.N(4), .BITS(16), .FRAC(8), .LANES(2)) dut (
    .clk(clk), .rst(rst), .act_mode(act_mode), .w_load(w_load), .w_init(w_init),
    .b_init(b_init), .fp_start(fp_start), .x(x), .bp_start(bp_start), .dz_in(dz_in),
    .lr(lr), .busy(busy), .y(y), .y_valid(y_valid), .dx(dx), .w_out(w_out),
    .b_out(b_out), .bp_done(bp_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          kind;   // 0: y_valid expected, 1: bp_done expected
    logic [15:0] y;
    logic [63:0] w;
    logic [15:0] b;
    logic [63:0] dx;
    int          cyc;
  } exp_t;
  exp_t q[$];

  longint m_w[4];
  longint m_x[4];
  longint m_b;
  longint m_z;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint mulq(input longint a, input longint b);
    return sat((a * b) >>> 8);
  endfunction

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] to16(input longint v);
    logic [63:0] t;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [63:0] pack4(input longint a[4]);
    logic [63:0] p;
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = to16(a[i]);
    return p;
  endfunction

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[16] ? r[15:0] : {{6{r[9]}}, r[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] wv, input logic [15:0] bv);
    tick();
    w_init = wv;
    b_init = bv;
    w_load = 1'b1;
    for (int i = 0; i < 4; i++) m_w[i] = s16(wv[i*16 +: 16]);
    m_b = s16(bv);
    tick();
    w_load = 1'b0;
    @(negedge clk);
    chk("load_w", w_out, wv);
  endtask

  task automatic fp(input logic [63:0] xv, input logic [1:0] act, input bit poke, input bit also_bp);
    exp_t   e;
    longint acc;
    longint z;
    longint yv;
    tick();
    x        = xv;
    act_mode = act;
    fp_start = 1'b1;
    bp_start = also_bp;
    dz_in    = 16'h0100;
    lr       = 16'h0040;
    acc = m_b * 256;
    for (int i = 0; i < 4; i++) begin
      m_x[i] = s16(xv[i*16 +: 16]);
      acc += m_w[i] * m_x[i];
    end
    z = sat(acc >>> 8);
    if (act == 2'd0)      yv = z;
    else if (act == 2'd2) yv = (z > 0) ? z : (z >>> 3);
    else                  yv = (z > 0) ? z : 0;
    m_z = z;
    e = '{kind: 1'b0, y: to16(yv), w: '0, b: '0, dx: '0, cyc: cyc + 4};
    q.push_back(e);
    tick();
    bp_start = 1'b0;
    fp_start = poke;
    if (poke) begin
      w_load = 1'b1;
      w_init = {rnd16(), rnd16(), rnd16(), rnd16()};
      x      = {rnd16(), rnd16(), rnd16(), rnd16()};
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("busy_fp", {63'd0, busy}, 64'd1);
      if (c == 1) begin
        fp_start = 1'b0;
        w_load   = 1'b0;
      end
      if (c < 3) tick();
    end
    tick();
    tick();
  endtask

  task automatic bp(input logic [15:0] dz, input logic [15:0] lrv, input logic [1:0] act);
    exp_t   e;
    longint d;
    longint dzl;
    longint g;
    longint dxm[4];
    tick();
    dz_in    = dz;
    lr       = lrv;
    act_mode = act;
    bp_start = 1'b1;
    d = s16(dz);
    if (act == 2'd0)      dzl = d;
    else if (act == 2'd2) dzl = (m_z > 0) ? d : (d >>> 3);
    else                  dzl = (m_z > 0) ? d : 0;
    g = mulq(s16(lrv), dzl);
    for (int i = 0; i < 4; i++) begin
      dxm[i] = mulq(m_w[i], dzl);
      m_w[i] = sat(m_w[i] - mulq(g, m_x[i]));
    end
    m_b = sat(m_b - g);
    e = '{kind: 1'b1, y: '0, w: pack4(m_w), b: to16(m_b), dx: pack4(dxm), cyc: cyc + 4};
    q.push_back(e);
    tick();
    bp_start = 1'b0;
    repeat (4) tick();
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (y_valid) begin
        if (q.size() == 0 || q[0].kind != 1'b0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_y_valid: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("y", {48'd0, y}, {48'd0, mon_e.y});
          chk("y_valid_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("busy_at_valid", {63'd0, busy}, 64'd0);
        end
      end
      if (bp_done) begin
        if (q.size() == 0 || q[0].kind != 1'b1) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bp_done: got pulse at cycle %0d, required none", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("bp_w", w_out, mon_e.w);
          chk("bp_b", {48'd0, b_out}, {48'd0, mon_e.b});
          chk("bp_dx", dx, mon_e.dx);
          chk("bp_done_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  localparam logic [63:0] W1 = 64'h0200_FF00_0080_0100;
  localparam logic [63:0] X1 = 64'h0080_0100_0200_0100;
  localparam logic [63:0] X2 = 64'h0000_0000_0000_FF00;

  initial begin
    rst = 1'b1; act_mode = 2'd0; w_load = 1'b0; w_init = '0; b_init = '0;
    fp_start = 1'b0; x = '0; bp_start = 1'b0; dz_in = '0; lr = '0;
    for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_x[i] = 0; end
    m_b = 0; m_z = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_y", {48'd0, y}, 64'd0);
    chk("rst_w", w_out, 64'd0);
    chk("rst_b", {48'd0, b_out}, 64'd0);
    chk("rst_dx", dx, 64'd0);
    chk("rst_pulses", {62'd0, y_valid, bp_done}, 64'd0);
    rst = 1'b0;

    load(W1, 16'h0080);
    fp(X1, 2'd1, 1'b0, 1'b0);
    chk("t1_y_plan", {48'd0, y}, 64'h0280);
    bp(16'h0100, 16'h0020, 2'd1);
    chk("t3_w_plan", w_out, 64'h01F0_FEE0_0040_00E0);
    chk("t3_b_plan", {48'd0, b_out}, 64'h0060);
    chk("t3_dx_plan", dx, W1);

    load(W1, 16'h0080);
    fp(X2, 2'd1, 1'b0, 1'b0);
    chk("t2_relu_plan", {48'd0, y}, 64'h0000);
    fp(X2, 2'd2, 1'b0, 1'b0);
    chk("t2_leaky_plan", {48'd0, y}, 64'hFFF0);
    fp(X2, 2'd0, 1'b0, 1'b0);
    chk("t2_lin_plan", {48'd0, y}, 64'hFF80);
    bp(16'h0100, 16'h0020, 2'd1);
    chk("t4_w_plan", w_out, W1);
    chk("t4_dx_plan", dx, 64'd0);
    bp(16'h0100, 16'h0020, 2'd2);

    load({4{16'h7F00}}, 16'h0000);
    fp({4{16'h7F00}}, 2'd1, 1'b0, 1'b0);
    chk("t5_pos_sat", {48'd0, y}, 64'h7FFF);
    load({4{16'h8000}}, 16'h0000);
    fp({4{16'h7F00}}, 2'd0, 1'b0, 1'b0);
    chk("t5_neg_sat", {48'd0, y}, 64'h8000);

    load(W1, 16'h0080);
    fp(X1, 2'd1, 1'b0, 1'b1);
    fp(X1, 2'd1, 1'b1, 1'b0);
    chk("t6_busy_ignore_w", w_out, W1);
    bp(16'h0100, 16'h0020, 2'd1);

    tick();
    x = X1; act_mode = 2'd1; fp_start = 1'b1;
    tick();
    fp_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_y", {48'd0, y}, 64'd0);
    chk("t6_rst_w", w_out, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_x[i] = 0; end
    m_b = 0; m_z = 0;
    repeat (3) tick();
    bp(16'h0100, 16'h0040, 2'd0);
    chk("bp_cold_b", {48'd0, b_out}, 64'hFFC0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0 || it == 0)
        load({rnd16(), rnd16(), rnd16(), rnd16()}, rnd16());
      fp({rnd16(), rnd16(), rnd16(), rnd16()}, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1)
        bp(rnd16(), rnd16(), 2'($urandom_range(0, 3)));
    end

    repeat (6) tick();
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_pulse: got none, required kind %0d at cycle %0d", mon_e.kind, mon_e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
